writeback_unit: RTL

Writeback stage that owns the register file's single write port (we, write_addr, result). It merges results from the single-cycle ALU and the variable-latency load unit, buffering load results in a small FIFO. It keeps a per-register pending scoreboard so decode can detect RAW hazards on source_a/source_b. It also provides same-cycle forwarding of the write in flight, which the register file read port cannot yet see.

---
 rtl/wb_if.sv | 31 +++
 rtl/writeback_unit.sv | 70 +++++++
 2 files changed

// File: rtl/wb_if.sv
// wb_if: writeback bundle; slave = writeback_unit (issue/ALU/load/decode in, handshake/write/hazard out), master = its environment
interface wb_if;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        we;
  logic [4:0]  write_addr;
  logic [31:0] result;
  logic [4:0]  source_a;
  logic [4:0]  source_b;
  logic        busy_a;
  logic        busy_b;
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] fwd_data;
  modport slave (
    input  iss_valid, iss_rd, alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, source_a, source_b,
    output alu_ready, mem_ready, we, write_addr, result, busy_a, busy_b, fwd_a, fwd_b, fwd_data
  );
  modport master (
    output iss_valid, iss_rd, alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, source_a, source_b,
    input  alu_ready, mem_ready, we, write_addr, result, busy_a, busy_b, fwd_a, fwd_b, fwd_data
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU results and FIFO-buffered loads onto the register write port (clk, async clr, wb: issue/ALU/load in, write/scoreboard hazards out)
module writeback_unit #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic clr,
  wb_if.slave  wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] L_LIM  = SW'(STARVE_LIMIT);
  logic [4:0]    r_q_rd   [DEPTH];
  logic [31:0]   r_q_data [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_starve;
  logic          r_we;
  logic [4:0]    r_addr;
  logic [31:0]   r_result;
  logic [31:0]   r_pend;
  logic          w_starve, w_empty, w_alu_win, w_pop, w_push;
  logic [31:0]   w_set, w_clr;
  assign w_starve     = r_starve == L_LIM;
  assign w_empty      = ~|r_count;
  assign wb.alu_ready = !w_starve;
  assign wb.mem_ready = r_count != L_FULL;
  assign w_alu_win    = wb.alu_valid && !w_starve && |wb.alu_rd;
  assign w_pop        = !w_alu_win && !w_empty;
  assign w_push       = wb.mem_valid && wb.mem_ready && |wb.mem_rd;
  assign w_set        = (wb.iss_valid && |wb.iss_rd) ? 32'd1 << wb.iss_rd : '0;
  assign w_clr        = r_we ? 32'd1 << r_addr : '0;
  assign wb.we         = r_we;
  assign wb.write_addr = r_addr;
  assign wb.result     = r_result;
  assign wb.fwd_data   = r_result;
  assign wb.fwd_a      = r_we && r_addr == wb.source_a && |wb.source_a;
  assign wb.fwd_b      = r_we && r_addr == wb.source_b && |wb.source_b;
  assign wb.busy_a     = r_pend[wb.source_a] && !wb.fwd_a;
  assign wb.busy_b     = r_pend[wb.source_b] && !wb.fwd_b;
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= wb.mem_rd;
      r_q_data[r_wptr] <= wb.mem_data;
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_result <= '0;
      r_pend   <= '0;
    end else begin
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_wptr   <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr   <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_starve <= w_pop ? '0 : (!w_empty && !w_starve) ? r_starve + SW'(1) : r_starve;
      r_we     <= w_alu_win || w_pop;
      r_addr   <= w_alu_win ? wb.alu_rd : w_pop ? r_q_rd[r_rptr] : r_addr;
      r_result <= w_alu_win ? wb.alu_data : w_pop ? r_q_data[r_rptr] : r_result;
      // set after clear so a same-edge reissue of the committing register stays pending
      r_pend   <= ((r_pend & ~w_clr) | w_set) & ~32'd1;
    end
  end
endmodule
